// File: rtl/decode_pkg.sv
// Shared types for the decode queue: buffered entry layout, decoded instruction
// format and RV64 major-opcode constants.
package decode_pkg;

  typedef enum logic [3:0] {
    OP_NONE, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE,
    OP_ADDI, OP_ALUI, OP_ALU, OP_MUL, OP_DIV, OP_FENCE, OP_PRIV
  } op_t;

  typedef struct packed {
    logic is_alu;
    logic is_branch;
    logic is_jump;
    logic is_load;
    logic is_store;
    logic is_multdiv;
    logic uses_imm;
    logic writes_rd;
  } ctl_t;

  typedef struct packed {
    op_t         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    ctl_t        ctl;
  } decoded_instr_t;

  typedef struct packed {
    logic [31:0] raw;
    logic [63:0] pc;
  } fq_entry_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/decode_queue_decoder.sv
// Combinational decoder for one buffered instruction word. An all-zero ctl with an
// opcode other than FENCE/SYSTEM marks the word as unsupported.
module decode_queue_decoder
  import decode_pkg::*;
(
  input  logic [31:0]    raw,
  output decoded_instr_t dec,
  output logic           illegal
);

  logic [2:0] f3;
  logic [6:0] f7;
  logic [31:0] imm_i;

  assign f3    = raw[14:12];
  assign f7    = raw[31:25];
  assign imm_i = {{20{raw[31]}}, raw[31:20]};

  always_comb begin
    dec     = '0;
    dec.rd  = raw[11:7];
    dec.rs1 = raw[19:15];
    dec.rs2 = raw[24:20];
    case (raw[6:0])
      OPC_LUI, OPC_AUIPC: begin
        dec.op  = (raw[6:0] == OPC_LUI) ? OP_LUI : OP_AUIPC;
        dec.imm = {raw[31:12], 12'b0};
        dec.ctl.is_alu    = 1'b1;
        dec.ctl.uses_imm  = 1'b1;
        dec.ctl.writes_rd = 1'b1;
      end
      OPC_JAL: begin
        dec.op  = OP_JAL;
        dec.imm = {{11{raw[31]}}, raw[31], raw[19:12], raw[20], raw[30:21], 1'b0};
        dec.ctl.is_jump   = 1'b1;
        dec.ctl.uses_imm  = 1'b1;
        dec.ctl.writes_rd = 1'b1;
      end
      OPC_JALR: if (f3 == 3'd0) begin
        dec.op  = OP_JALR;
        dec.imm = imm_i;
        dec.ctl.is_jump   = 1'b1;
        dec.ctl.uses_imm  = 1'b1;
        dec.ctl.writes_rd = 1'b1;
      end
      OPC_BRANCH: if (f3 != 3'd2 && f3 != 3'd3) begin
        dec.op  = OP_BRANCH;
        dec.imm = {{19{raw[31]}}, raw[31], raw[7], raw[30:25], raw[11:8], 1'b0};
        dec.ctl.is_branch = 1'b1;
        dec.ctl.uses_imm  = 1'b1;
      end
      OPC_LOAD: if (f3 != 3'd7) begin
        dec.op  = OP_LOAD;
        dec.imm = imm_i;
        dec.ctl.is_load   = 1'b1;
        dec.ctl.uses_imm  = 1'b1;
        dec.ctl.writes_rd = 1'b1;
      end
      OPC_STORE: if (!f3[2]) begin
        dec.op  = OP_STORE;
        dec.imm = {{20{raw[31]}}, raw[31:25], raw[11:7]};
        dec.ctl.is_store  = 1'b1;
        dec.ctl.uses_imm  = 1'b1;
      end
      OPC_OPIMM: begin
        dec.op  = (f3 == 3'd0) ? OP_ADDI : OP_ALUI;
        dec.imm = imm_i;
        dec.ctl.is_alu    = 1'b1;
        dec.ctl.uses_imm  = 1'b1;
        dec.ctl.writes_rd = 1'b1;
      end
      OPC_OP: begin
        if (f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5))) begin
          dec.op = OP_ALU;
          dec.ctl.is_alu    = 1'b1;
          dec.ctl.writes_rd = 1'b1;
        end else if (f7 == 7'b0000001 && (f3 == 3'd0 || f3[2])) begin
          // MULH/MULHSU/MULHU fall through with an empty ctl
          dec.op = (f3 == 3'd0) ? OP_MUL : OP_DIV;
          dec.ctl.is_multdiv = 1'b1;
          dec.ctl.writes_rd  = 1'b1;
        end
      end
      OPC_FENCE:  dec.op = OP_FENCE;
      OPC_SYSTEM: dec.op = OP_PRIV;
      default: ;
    endcase
    illegal = (dec.ctl == '0) && (dec.op != OP_FENCE) && (dec.op != OP_PRIV);
  end

endmodule

// File: rtl/decode_queue.sv
// Circular buffer between fetch and issue: accepts up to FETCH_WIDTH raw
// instructions per cycle and presents up to ISSUE_WIDTH decoded entries from head.
module decode_queue
  import decode_pkg::*;
#(
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH       = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                flush,
  input  logic                                in_valid,
  input  logic [$clog2(FETCH_WIDTH+1)-1:0]    in_cnt,
  input  logic [FETCH_WIDTH-1:0][31:0]        in_instr,
  input  logic [FETCH_WIDTH-1:0][63:0]        in_pc,
  output logic                                in_ready,
  output logic [ISSUE_WIDTH-1:0]              out_valid,
  output decoded_instr_t [ISSUE_WIDTH-1:0]    out_instr,
  output logic [ISSUE_WIDTH-1:0][63:0]        out_pc,
  output logic [ISSUE_WIDTH-1:0]              out_illegal,
  input  logic [$clog2(ISSUE_WIDTH+1)-1:0]    out_accept,
  output logic [$clog2(DEPTH+1)-1:0]          count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(FETCH_WIDTH+1);

  fq_entry_t       mem [DEPTH];
  fq_entry_t       rd_entry [ISSUE_WIDTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic            push;
  logic [IW-1:0]   pushed;

  assign in_ready = (count <= CW'(DEPTH - FETCH_WIDTH));
  assign push     = in_valid && in_ready && !flush && !reset;
  assign pushed   = push ? in_cnt : '0;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(out_accept);
      tail  <= tail + PW'(pushed);
      count <= count + CW'(pushed) - CW'(out_accept);
    end
  end

  // Storage is not reset; occupancy is tracked solely by head/count.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
        if (i < 32'(in_cnt)) mem[tail + PW'(i)] <= '{raw: in_instr[i], pc: in_pc[i]};
      end
    end
  end

  always_comb begin
    out_valid = '0;
    for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
      out_valid[i] = (count > CW'(i));
      rd_entry[i]  = mem[head + PW'(i)];
      out_pc[i]    = rd_entry[i].pc;
    end
  end

  for (genvar g = 0; g < ISSUE_WIDTH; g++) begin : g_dec
    decode_queue_decoder u_dec (
      .raw     (rd_entry[g].raw),
      .dec     (out_instr[g]),
      .illegal (out_illegal[g])
    );
  end

  accept_in_range: assert property (@(posedge clk) disable iff (reset || flush)
    int'(out_accept) <= $countones(out_valid));

endmodule

// File: tb/tb_decode_queue.sv
// Randomized and directed bench for decode_queue, checked every cycle against a
// queue-based model and a table of known instruction encodings.
module tb_decode_queue;
  import decode_pkg::*;

  localparam int FW    = 2;
  localparam int IWD   = 2;
  localparam int DEPTH = 8;

  logic                    clk;
  logic                    reset, flush, in_valid, in_ready;
  logic [1:0]              in_cnt, out_accept;
  logic [FW-1:0][31:0]     in_instr;
  logic [FW-1:0][63:0]     in_pc;
  logic [IWD-1:0]          out_valid, out_illegal;
  decoded_instr_t [IWD-1:0] out_instr;
  logic [IWD-1:0][63:0]    out_pc;
  logic [3:0]              count;

  decode_queue #(.FETCH_WIDTH(FW), .ISSUE_WIDTH(IWD), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_cnt(in_cnt),
    .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready), .out_valid(out_valid),
    .out_instr(out_instr), .out_pc(out_pc), .out_illegal(out_illegal),
    .out_accept(out_accept), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] raw;
    op_t         op;
    logic        ill;
    logic [31:0] imm;
  } tv_t;

  typedef struct {
    int          idx;
    logic [63:0] pc;
  } ent_t;

  localparam int T_ADDI5 = 0, T_NOP = 1, T_NEG = 2, T_MUL = 3, T_MULH = 4, T_ONES = 5,
                 T_ZERO = 6, T_FENCE = 7, T_ECALL = 8, T_LUI = 9, T_ADD = 10,
                 T_DIV = 11, T_LD = 12, NTBL = 13;

  tv_t  tbl [NTBL];
  ent_t mq [$];
  int   drv_idx [FW];
  int   tests, fails;
  bit   chk_en;

  initial begin
    tbl[T_ADDI5] = '{32'h00500093, OP_ADDI,  1'b0, 32'd5};
    tbl[T_NOP]   = '{32'h00000013, OP_ADDI,  1'b0, 32'd0};
    tbl[T_NEG]   = '{32'hFFF00093, OP_ADDI,  1'b0, 32'hFFFFFFFF};
    tbl[T_MUL]   = '{32'h02208033, OP_MUL,   1'b0, 32'd0};
    tbl[T_MULH]  = '{32'h02209033, OP_NONE,  1'b1, 32'd0};
    tbl[T_ONES]  = '{32'hFFFFFFFF, OP_NONE,  1'b1, 32'd0};
    tbl[T_ZERO]  = '{32'h00000000, OP_NONE,  1'b1, 32'd0};
    tbl[T_FENCE] = '{32'h0000000F, OP_FENCE, 1'b0, 32'd0};
    tbl[T_ECALL] = '{32'h00000073, OP_PRIV,  1'b0, 32'd0};
    tbl[T_LUI]   = '{32'h12345037, OP_LUI,   1'b0, 32'h12345000};
    tbl[T_ADD]   = '{32'h002081B3, OP_ALU,   1'b0, 32'd0};
    tbl[T_DIV]   = '{32'h0220C033, OP_DIV,   1'b0, 32'd0};
    tbl[T_LD]    = '{32'h00813083, OP_LOAD,  1'b0, 32'd8};
  end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference behaviour: occupancy is a plain queue; ready is judged before the update.
  always @(posedge clk) begin
    bit rdy;
    rdy = (DEPTH - mq.size()) >= FW;
    if (reset || flush) begin
      mq.delete();
    end else begin
      for (int a = 0; a < int'(out_accept); a++) if (mq.size() > 0) void'(mq.pop_front());
      if (in_valid && rdy)
        for (int k = 0; k < int'(in_cnt); k++) mq.push_back('{drv_idx[k], in_pc[k]});
    end
  end

  always @(negedge clk) begin
    int n;
    ent_t e;
    if (chk_en) begin
      n = mq.size();
      chk("count", 64'(count), 64'(n));
      chk("in_ready", 64'(in_ready), 64'((DEPTH - n) >= FW));
      for (int i = 0; i < IWD; i++) begin
        chk("out_valid", 64'(out_valid[i]), 64'(i < n));
        if (i < n) begin
          e = mq[i];
          chk("out_pc", out_pc[i], e.pc);
          chk("out_op", 64'(out_instr[i].op), 64'(tbl[e.idx].op));
          chk("out_illegal", 64'(out_illegal[i]), 64'(tbl[e.idx].ill));
          chk("out_imm", 64'(out_instr[i].imm), 64'(tbl[e.idx].imm));
        end
      end
    end
  end

  task automatic drive(input bit v, input int cnt, input int i0, input int i1,
                       input logic [63:0] pc0, input int acc, input bit fl, input bit rs);
    in_valid    = v;
    in_cnt      = 2'(cnt);
    in_instr[0] = tbl[i0].raw;
    in_instr[1] = tbl[i1].raw;
    in_pc[0]    = pc0;
    in_pc[1]    = pc0 + 64'd4;
    drv_idx[0]  = i0;
    drv_idx[1]  = i1;
    out_accept  = 2'(acc);
    flush       = fl;
    reset       = rs;
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] pc;
    int n, acc;
    tests = 0; fails = 0; chk_en = 0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_cnt = '0; out_accept = '0;
    in_instr = '0; in_pc = '0; drv_idx[0] = 0; drv_idx[1] = 0;
    @(negedge clk);
    drive(0, 0, T_NOP, T_NOP, 64'd0, 0, 0, 1);
    chk_en = 1;
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_ready", 64'(in_ready), 64'd1);
    chk("reset_valid", 64'(out_valid), 64'd0);

    drive(1, 2, T_ADDI5, T_NOP, 64'h80000000, 0, 0, 0);
    chk("first_valid", 64'(out_valid), 64'b11);
    chk("first_op", 64'(out_instr[0].op), 64'(OP_ADDI));
    chk("first_imm", 64'(out_instr[0].imm), 64'd5);
    chk("first_illegal", 64'(out_illegal), 64'b00);
    drive(0, 0, T_NOP, T_NOP, 64'd0, 2, 0, 0);

    pc = 64'h1000;
    for (int g = 0; g < 4; g++) begin
      drive(1, 2, T_LUI, T_LD, pc, 0, 0, 0);
      pc += 64'd8;
    end
    chk("full_count", 64'(count), 64'd8);
    chk("full_ready", 64'(in_ready), 64'd0);
    chk("model_full", 64'(mq.size()), 64'd8);
    drive(0, 0, T_NOP, T_NOP, 64'd0, 2, 0, 0);
    chk("after_accept_ready", 64'(in_ready), 64'd1);
    for (int g = 0; g < 3; g++) drive(0, 0, T_NOP, T_NOP, 64'd0, 2, 0, 0);

    drive(1, 2, T_ONES, T_MUL, 64'h2000, 0, 0, 0);
    chk("illegal_pair", 64'(out_illegal), 64'b01);
    chk("mul_multdiv", 64'(out_instr[1].ctl.is_multdiv), 64'd1);
    drive(1, 1, T_MULH, T_NOP, 64'h2008, 2, 0, 0);
    chk("mulh_illegal", 64'(out_illegal[0]), 64'd1);
    drive(0, 0, T_NOP, T_NOP, 64'd0, 1, 0, 0);

    drive(1, 2, T_ADD, T_DIV, 64'h3000, 0, 0, 0);
    drive(1, 2, T_FENCE, T_ECALL, 64'h3008, 0, 0, 0);
    drive(1, 1, T_NEG, T_NOP, 64'h3010, 0, 0, 0);
    chk("pre_flush_count", 64'(count), 64'd5);
    drive(1, 2, T_NOP, T_NOP, 64'h3018, 1, 1, 0);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);

    drive(1, 2, T_NOP, T_ADD, 64'h4000, 0, 0, 0);
    drive(1, 1, T_LD, T_NOP, 64'h4008, 0, 0, 0);
    chk("pre_reset_count", 64'(count), 64'd3);
    drive(1, 2, T_ADDI5, T_ADDI5, 64'h4010, 0, 0, 1);
    chk("midreset_count", 64'(count), 64'd0);
    drive(0, 0, T_NOP, T_NOP, 64'd0, 0, 0, 0);
    chk("midreset_valid", 64'(out_valid), 64'd0);

    pc = 64'h5000;
    drive(1, 2, T_NOP, T_ADD, pc, 0, 0, 0);
    for (int c = 0; c < 20; c++) begin
      pc += 64'd8;
      drive(1, 2, T_ADDI5, T_LD, pc, 2, 0, 0);
      chk("steady_count", 64'(count), 64'd2);
    end

    for (int c = 0; c < 600; c++) begin
      n = mq.size();
      acc = $urandom_range(0, (n < IWD) ? n : IWD);
      pc += 64'd8;
      drive(1'($urandom_range(0, 3) != 0), $urandom_range(0, FW),
            $urandom_range(0, NTBL - 1), $urandom_range(0, NTBL - 1), pc, acc,
            1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 79) == 0));
    end
    drive(0, 0, T_NOP, T_NOP, 64'd0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 SHALL have parameter FETCH_WIDTH, default 2: max raw instructions accepted per cycle.
REQ-002 SHALL have parameter ISSUE_WIDTH, default 2: max decoded instructions presented per cycle.
REQ-003 SHALL have parameter DEPTH, default 8: buffer entries; power of two and >= max(FETCH_WIDTH, ISSUE_WIDTH).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 flush  input  1  discard all buffered entries.
REQ-008 in_valid  input  1  fetch group offered.
REQ-009 in_cnt  input  $clog2(FETCH_WIDTH+1)  valid slots in the group, contiguous from slot 0.
REQ-010 in_instr  input  FETCH_WIDTH x 32  raw instructions; slot 0 is oldest.
REQ-011 in_pc  input  FETCH_WIDTH x 64  PC per slot.
REQ-012 in_ready  output  1  at least FETCH_WIDTH entries free.
REQ-013 out_valid  output  ISSUE_WIDTH  thermometer code; bit i set iff entry head+i is occupied.
REQ-014 out_instr  output  ISSUE_WIDTH x decoded_instr_t  decoded entry head+i.
REQ-015 out_pc  output  ISSUE_WIDTH x 64  PC of entry head+i.
REQ-016 out_illegal  output  ISSUE_WIDTH  entry head+i is not a supported encoding.
REQ-017 out_accept  input  $clog2(ISSUE_WIDTH+1)  entries consumed this cycle, oldest first.
REQ-018 count  output  $clog2(DEPTH+1)  occupied entries.

Function
REQ-019 Push SHALL occur when in_valid && in_ready && !flush, writing in_cnt entries at tail in slot order; in_cnt=0 pushes nothing.
REQ-020 Pop SHALL remove out_accept entries from head when !flush; out_accept greater than popcount(out_valid) is a protocol violation, flagged by a simulation assertion.
REQ-021 Push and pop in the same cycle SHALL both take effect; count_next = count + pushed - popped.
REQ-022 in_ready SHALL be a function of registered count only (DEPTH - count >= FETCH_WIDTH), with no combinational path from out_accept.
REQ-023 Head and tail pointers SHALL wrap modulo DEPTH; program order SHALL be preserved across wrap.
REQ-024 An entry pushed in cycle t SHALL be visible on out_valid in cycle t+1; no same-cycle bypass.
REQ-025 Decode SHALL be combinational from stored entries to out_instr, out_illegal and out_pc.
REQ-026 out_illegal[i] SHALL be set when the decoded ctl is all-zero and the opcode is neither OP_FENCE nor OP_PRIV. This covers unsupported MULH/MULHSU/MULHU and all-zero words.
REQ-027 out_instr/out_pc/out_illegal SHALL be don't-care where out_valid[i]=0.
REQ-028 Flush SHALL have priority over push and pop in the same cycle: next cycle count=0, head=tail=0, out_valid=0.
REQ-029 Full state (count=DEPTH) SHALL hold in_ready=0; empty state SHALL hold out_valid=0.

Reset
REQ-030 On reset: count=0, head=tail=0, out_valid=0, in_ready=1 from the next cycle.
REQ-031 Reset SHALL override flush, push and pop; the buffer storage array needs no reset.
REQ-032 Reset asserted mid-stream SHALL discard all entries, with no partial group retained.

Structure
REQ-033 Typedef fq_entry_t {u32 raw; u64 pc} SHALL reside in decode_pkg.
REQ-034 ISSUE_WIDTH instances of the existing decoder sub-module SHALL perform decode, one per output slot.
REQ-035 Pointer and count arithmetic SHALL live in this module; no separate FIFO module.

Verification
REQ-036 Reset, then push {0x00500093 @0x80000000, 0x00000013 @0x80000004} -> next cycle out_valid=2'b11, slot0 op=ADDI, imm=5, out_illegal=00.
REQ-037 Push 4 groups of 2 with out_accept=0 (DEPTH=8) -> count=8, in_ready=0; accept 2 -> in_ready=1 the following cycle.
REQ-038 Steady push of 2 and accept of 2 over 20 cycles with incrementing PCs -> PCs leave in order across pointer wrap; count stays at 2.
REQ-039 Push {0xFFFFFFFF, 0x02208033} -> out_illegal=01 for 0xFFFFFFFF and 0 for MUL (ctl.is_multdiv=1); MULH 0x02209033 -> illegal=1.
REQ-040 Count=5, then flush together with push 2 and accept 1 -> next cycle count=0, out_valid=0, in_ready=1.
REQ-041 Reset asserted while count=3 and in_valid=1 -> next cycle count=0, and the pushed group is absent.
